pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Holds the architectural PC, fetches instructions from instruction memory, and presents them to decode with a valid/ready handshake.
- Consumes the combinational next-PC value produced by the npc logic.
- Sits between the npc logic and the decode stage.
- Keeps one sequential prefetch slot (PC+4) so straight-line code issues back-to-back.
- Discards the prefetch when next-PC is not PC+4.

Parameters:
- RESET_PC, 32'h00003000, PC loaded on reset; also the first fetch address.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc  out  32  PC of the instruction currently presented on instr; feeds npc.
- next_pc  in  32  next-PC from npc, computed from pc; sampled only at handshake.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; valid while imem_req=1.
- imem_gnt  in  1  memory accepts request in this cycle.
- imem_rvalid  in  1  read data valid; at most one outstanding; at least 1 cycle after gnt.
- imem_rdata  in  32  read data.
- instr_valid  out  1  instr/pc valid for decode.
- instr  out  32  fetched instruction.
- instr_ready  in  1  decode accepts instr this cycle.
- fault  out  1  sticky misaligned-PC fault.

Behaviour:
- Handshake: fire = instr_valid & instr_ready.
- At fire, the block samples next_pc, sets pc <= next_pc, and defines seq = (next_pc == pc+4). pc changes only at fire.
- Interface contract:
  - imem_req and imem_addr are registered outputs.
  - The request is withdrawn or its address changed only while no gnt has occurred for it.
  - The memory must tolerate withdrawal.
  - rvalid while no request is outstanding is illegal (assertion).
- Reset (asynchronous):
  - pc = RESET_PC, state = FETCH, instr_valid = 0, instr = 0, fault = 0.
  - imem_req = 1, imem_addr = RESET_PC once reset deasserts.
  - Reset mid-transaction drops any outstanding response. The memory is reset on the same reset.
- States:
  - FETCH: req=1, addr=pc, instr_valid=0. On gnt -> WAIT.
  - WAIT: req=0. On rvalid: instr <= rdata, instr_valid <= 1 -> PF_REQ.
  - PF_REQ: instr_valid=1, req=1, addr=pc+4. Without fire, gnt -> PF_WAIT. Fire cases:
    - seq: -> FETCH with addr=next_pc, which is the same address. A same-cycle gnt -> WAIT instead.
    - non-seq: -> FETCH, or -> DRAIN if gnt occurs in the same cycle.
  - PF_WAIT: instr_valid=1, req=0. Without fire, rvalid: pf_instr <= rdata -> READY. Fire cases:
    - seq without rvalid: instr_valid <= 0 -> WAIT; the pending response becomes instr.
    - seq with rvalid: instr <= rdata, instr_valid stays 1 -> PF_REQ.
    - non-seq without rvalid: -> DRAIN.
    - non-seq with rvalid: discard the data -> FETCH.
  - READY: instr_valid=1, req=0, prefetch held. Fire cases:
    - seq: instr <= pf_instr, instr_valid stays 1 -> PF_REQ for the new pc+4. This gives zero-bubble sequential issue.
    - non-seq: discard pf -> FETCH.
  - DRAIN: instr_valid=0, req=0. On rvalid: discard -> FETCH.
  - FAULT: terminal until reset. instr_valid=0, req=0, fault=1. rvalid is ignored.
- Misalignment: next_pc[1:0] != 0 at fire -> FAULT from any state. pc still updates to next_pc for debug. Any outstanding response is absorbed silently.
- Arithmetic: pc+4 is 32-bit modulo. 0xFFFFFFFC+4 = 0x00000000, which is seq.
- Stall: while instr_ready=0, instr and pc are held stable and the prefetch proceeds up to READY. No more than one prefetch is outstanding.

Test Plan:
- Reset, memory with 1-cycle latency returning 0x11111111@0x3000, 0x22222222@0x3004, instr_ready=1, next_pc=pc+4 -> first instr_valid with pc=0x3000. After the first prefetch completes, consecutive fires occur every 2 cycles with pc 0x3004, 0x3008.
- instr_ready=0 for 10 cycles with instr valid at pc=0x3000 -> exactly one request to 0x3004. State reaches READY, instr holds 0x11111111. On release, the next cycle shows instr=0x22222222 at pc=0x3004 with instr_valid continuously 1.
- Fire at pc=0x3000 with next_pc=0x3400 while the prefetch to 0x3004 is in PF_WAIT -> response for 0x3004 discarded (DRAIN). Then req to 0x3400, and instr_valid stays 0 until the 0x3400 data arrives.
- Fire with next_pc=0x3402 -> fault=1 next cycle, instr_valid=0, imem_req=0. Both stay that way until reset. Asserting reset clears fault and restarts at 0x3000.
- In PF_WAIT, sequential fire coincident with rvalid=0x33333333 -> next cycle instr=0x33333333, instr_valid=1, req to pc+4.
- Assert reset asynchronously mid-WAIT -> outputs reach reset values without a clock edge. After release, the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: holds the architectural PC, fetches from instruction memory and
// presents instructions to decode over valid/ready, with one sequential prefetch slot.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        instr_ready,
  output logic        fault
);

  typedef enum logic [2:0] {
    StFetch,
    StWait,
    StPfReq,
    StPfWait,
    StReady,
    StDrain,
    StFault
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pf_q, pf_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;

  logic        fire;
  logic        seq;
  logic        misaligned;
  logic        gnt;
  logic        outstanding;

  assign instr_valid = (state_q == StPfReq) || (state_q == StPfWait) || (state_q == StReady);
  assign fire        = instr_valid & instr_ready;
  // 32-bit wrap is intentional: 0xFFFFFFFC -> 0x00000000 counts as sequential
  assign seq         = (next_pc == pc_q + 32'd4);
  assign misaligned  = (next_pc[1:0] != 2'b00);
  assign gnt         = imem_gnt & req_q;

  assign pc        = pc_q;
  assign instr     = instr_q;
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign fault     = (state_q == StFault);

  // Next-state, PC update, instruction/prefetch capture and registered request
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pf_d    = pf_q;

    if (fire) pc_d = next_pc;

    unique case (state_q)
      StFetch: begin
        if (gnt) state_d = StWait;
      end
      StWait: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = StPfReq;
        end
      end
      StPfReq: begin
        if (fire) begin
          // A granted prefetch of pc+4 is exactly the new instruction when seq
          if (seq) state_d = gnt ? StWait : StFetch;
          else     state_d = gnt ? StDrain : StFetch;
        end else if (gnt) begin
          state_d = StPfWait;
        end
      end
      StPfWait: begin
        if (fire) begin
          if (seq) begin
            if (imem_rvalid) begin
              instr_d = imem_rdata;
              state_d = StPfReq;
            end else begin
              state_d = StWait;
            end
          end else begin
            state_d = imem_rvalid ? StFetch : StDrain;
          end
        end else if (imem_rvalid) begin
          pf_d    = imem_rdata;
          state_d = StReady;
        end
      end
      StReady: begin
        if (fire) begin
          if (seq) begin
            instr_d = pf_q;
            state_d = StPfReq;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StDrain: begin
        if (imem_rvalid) state_d = StFetch;
      end
      StFault: begin
        state_d = StFault;
      end
      default: state_d = StFault;
    endcase

    // Misaligned target wins over every other transition
    if (fire && misaligned) state_d = StFault;

    req_d  = (state_d == StFetch) || (state_d == StPfReq);
    addr_d = (state_d == StPfReq) ? pc_d + 32'd4 : pc_d;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pf_q    <= 32'h0;
      req_q   <= 1'b1;
      addr_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pf_q    <= pf_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
    end
  end

  // A response may only arrive while one is outstanding; FAULT may absorb a late one
  assign outstanding = (state_q == StWait) || (state_q == StPfWait) ||
                       (state_q == StDrain) || (state_q == StFault);

  assert property (@(posedge clk) disable iff (reset) imem_rvalid |-> outstanding);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and random stimulus against an instruction-stream model
// and a single-outstanding memory model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc;
  logic [31:0] next_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready = 1'b0;
  logic        fault;

  pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .next_pc     (next_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // memory model: one outstanding request, response lat cycles after grant
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat_min = 1, lat_max = 1, gnt_pct = 100;
  // ready_mode: 0 low, 1 high, 2 random; npc_mode: 0 seq, 1 target, 2 random, 3 target@reset pc
  int          ready_mode = 1, npc_mode = 0;
  logic [31:0] npc_target = 32'h0;

  // instruction-stream model
  logic [31:0] exp_pc;
  int          cyc = 0, fire_cnt = 0, last_fire_cyc = 0, fire_gap = 0;
  int          grant_cnt = 0;
  logic [31:0] last_grant_addr = 32'h0;

  logic        prev_req, prev_gnt, prev_rvalid, prev_fire, prev_valid;
  logic [31:0] prev_addr, prev_pc, prev_instr, prev_npc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'h0000_3000: return 32'h1111_1111;
      32'h0000_3004: return 32'h2222_2222;
      32'h0000_3008: return 32'h3333_3333;
      default:       return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_prev();
    prev_req = 0; prev_gnt = 0; prev_rvalid = 0; prev_fire = 0; prev_valid = 0;
    prev_addr = 0; prev_pc = 0; prev_instr = 0; prev_npc = 0;
  endtask

  // One clock: account for the edge just passed, then drive inputs for the next edge
  task automatic cycle();
    int r;
    @(negedge clk);
    cyc++;
    if (prev_rvalid) mem_busy = 0;
    if (prev_req && prev_gnt) begin
      mem_busy = 1;
      mem_addr = prev_addr;
      mem_cnt = $urandom_range(lat_max, lat_min);
      grant_cnt++;
      last_grant_addr = prev_addr;
    end
    if (prev_fire) begin
      check("fire_pc", prev_pc, exp_pc);
      check("fire_instr", prev_instr, mem_data(prev_pc));
      exp_pc = prev_npc;
      if (fire_cnt > 0) fire_gap = cyc - last_fire_cyc;
      last_fire_cyc = cyc;
      fire_cnt++;
    end else if (prev_valid) begin
      check("hold_valid", instr_valid, 1);
      check("hold_pc", pc, prev_pc);
      check("hold_instr", instr, prev_instr);
    end
    check("req_while_busy", imem_req & mem_busy, 0);

    imem_gnt = 0;
    imem_rvalid = 0;
    imem_rdata = $urandom();
    if (mem_busy) begin
      if (mem_cnt <= 1) begin
        imem_rvalid = 1;
        imem_rdata = mem_data(mem_addr);
      end else begin
        mem_cnt--;
      end
    end else if (imem_req && ($urandom_range(99, 0) < gnt_pct)) begin
      imem_gnt = 1;
    end

    case (ready_mode)
      0:       instr_ready = 0;
      1:       instr_ready = 1;
      default: instr_ready = ($urandom_range(99, 0) < 60);
    endcase

    case (npc_mode)
      0: next_pc = pc + 32'd4;
      1: next_pc = npc_target;
      2: begin
        r = $urandom_range(99, 0);
        if (r < 80)      next_pc = pc + 32'd4;
        else if (r < 84) next_pc = 32'hFFFF_FFF8;
        else             next_pc = 32'h0000_3000 + ($urandom_range(1023, 0) << 2);
      end
      default: next_pc = (pc == RESET_PC) ? npc_target : pc + 32'd4;
    endcase

    prev_req = imem_req; prev_addr = imem_addr; prev_gnt = imem_gnt;
    prev_rvalid = imem_rvalid; prev_fire = instr_valid & instr_ready;
    prev_valid = instr_valid; prev_pc = pc; prev_instr = instr; prev_npc = next_pc;
  endtask

  // Assert reset now, check the asynchronous reset values, release on a later negedge
  task automatic apply_reset();
    reset = 1;
    mem_busy = 0;
    clear_prev();
    imem_gnt = 0; imem_rvalid = 0; instr_ready = 0; next_pc = 0;
    #1;
    check("rst_pc", pc, RESET_PC);
    check("rst_req", imem_req, 1);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_fault", fault, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    exp_pc = RESET_PC;
    fire_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;

    // T1: straight-line fetch, 1-cycle memory
    gnt_pct = 100; lat_min = 1; lat_max = 1; ready_mode = 1; npc_mode = 0;
    do_reset();
    n = 0;
    while (!instr_valid && n < 20) begin cycle(); n++; end
    check("t1_first_valid", instr_valid, 1);
    check("t1_first_pc", pc, 32'h3000);
    check("t1_first_instr", instr, 32'h1111_1111);
    n = 0;
    while (fire_cnt < 3 && n < 30) begin cycle(); n++; end
    check("t1_fire_count", fire_cnt, 3);
    check("t1_fire_gap", fire_gap, 2);

    // T2: decode stalls 10 cycles, prefetch completes into the slot
    ready_mode = 0;
    do_reset();
    n = 0;
    while (!instr_valid && n < 20) begin cycle(); n++; end
    n = grant_cnt;
    repeat (10) cycle();
    check("t2_one_prefetch", grant_cnt - n, 1);
    check("t2_pf_addr", last_grant_addr, 32'h3004);
    check("t2_stall_valid", instr_valid, 1);
    check("t2_stall_req", imem_req, 0);
    check("t2_stall_instr", instr, 32'h1111_1111);
    check("t2_stall_pc", pc, 32'h3000);
    ready_mode = 1;
    cycle();
    check("t2_release_valid0", instr_valid, 1);
    cycle();
    check("t2_next_instr", instr, 32'h2222_2222);
    check("t2_next_pc", pc, 32'h3004);
    check("t2_next_valid", instr_valid, 1);
    check("t2_next_req_addr", imem_addr, 32'h3008);

    // T3: branch while the prefetch is outstanding
    ready_mode = 0; lat_min = 3; lat_max = 3;
    do_reset();
    n = 0;
    while (!(instr_valid && !imem_req) && n < 30) begin cycle(); n++; end
    check("t3_in_pf_wait", instr_valid & ~imem_req, 1);
    ready_mode = 1; npc_mode = 1; npc_target = 32'h3400;
    cycle();
    ready_mode = 0;
    cycle();
    check("t3_drain_valid", instr_valid, 0);
    check("t3_drain_req", imem_req, 0);
    check("t3_branch_pc", pc, 32'h3400);
    seen = 0;
    n = 0;
    while (!imem_req && n < 10) begin cycle(); seen |= instr_valid; n++; end
    check("t3_req_addr", imem_addr, 32'h3400);
    n = 0;
    while (!instr_valid && n < 20) begin cycle(); n++; end
    check("t3_early_valid", seen, 0);
    check("t3_instr", instr, mem_data(32'h3400));
    check("t3_pc", pc, 32'h3400);

    // T4: misaligned target faults and sticks until reset
    npc_target = 32'h3402; ready_mode = 1;
    cycle();
    ready_mode = 0;
    cycle();
    check("t4_fault", fault, 1);
    check("t4_valid", instr_valid, 0);
    check("t4_req", imem_req, 0);
    check("t4_pc", pc, 32'h3402);
    ready_mode = 2; npc_mode = 2;
    repeat (8) begin
      cycle();
      check("t4_sticky_fault", fault, 1);
      check("t4_sticky_valid", instr_valid, 0);
      check("t4_sticky_req", imem_req, 0);
    end
    ready_mode = 1; npc_mode = 0; lat_min = 1; lat_max = 1;
    do_reset();
    n = 0;
    while (!instr_valid && n < 20) begin cycle(); n++; end
    check("t4_restart_pc", pc, 32'h3000);
    check("t4_restart_fault", fault, 0);

    // T5: sequential fire in PF_WAIT coincident with the prefetch response
    lat_min = 2; lat_max = 2;
    do_reset();
    n = 0;
    while (pc != 32'h3004 && n < 20) begin cycle(); n++; end
    ready_mode = 0;
    n = 0;
    while (!(instr_valid && !imem_req && mem_busy && mem_cnt == 1) && n < 20) begin
      cycle(); n++;
    end
    check("t5_setup_pc", pc, 32'h3004);
    ready_mode = 1;
    cycle();
    ready_mode = 0;
    cycle();
    check("t5_instr", instr, 32'h3333_3333);
    check("t5_valid", instr_valid, 1);
    check("t5_req", imem_req, 1);
    check("t5_addr", imem_addr, 32'h300C);
    check("t5_pc", pc, 32'h3008);

    // T6: asynchronous reset while waiting for a response
    lat_min = 3; lat_max = 3; ready_mode = 1;
    do_reset();
    n = 0;
    while (!(fire_cnt >= 2 && !instr_valid && !imem_req) && n < 40) begin cycle(); n++; end
    check("t6_mid_wait_pc", pc, 32'h3008);
    #2;
    apply_reset();
    n = 0;
    while (!instr_valid && n < 20) begin cycle(); n++; end
    check("t6_restart_addr", last_grant_addr, 32'h3000);
    check("t6_restart_pc", pc, 32'h3000);
    check("t6_restart_instr", instr, 32'h1111_1111);

    // T8: wrap 0xFFFFFFFC -> 0x00000000 stays on the sequential path
    lat_min = 1; lat_max = 1; npc_mode = 3; npc_target = 32'hFFFF_FFFC;
    do_reset();
    n = 0;
    while (fire_cnt < 3 && n < 40) begin cycle(); n++; end
    check("t8_wrap_fires", fire_cnt, 3);
    check("t8_wrap_gap", fire_gap, 2);
    check("t8_wrap_pc", exp_pc, 32'h0000_0004);

    // T7: random grants, latency, stalls and branches
    gnt_pct = 70; lat_min = 1; lat_max = 3; ready_mode = 2; npc_mode = 2;
    do_reset();
    repeat (3000) cycle();
    check("t7_progress", fire_cnt > 100, 1);
    check("t7_no_fault", fault, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
